// File: rtl/dt_engine_if.sv
// Handshake, stimulus-ROM and result-RAM bundle of the distance-transform engine.
// The master modport is the engine side; the slave modport is the job controller and memories.
interface dt_engine_if #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int STI_W  = 16,
  parameter int DIST_W = 8
);
  localparam int AW  = $clog2(IMG_W * IMG_H);
  localparam int SAW = $clog2(IMG_W * IMG_H / STI_W);

  logic              start;
  logic              metric;
  logic              busy;
  logic              done;
  logic              sti_rd;
  logic [SAW-1:0]    sti_addr;
  logic [STI_W-1:0]  sti_di;
  logic              res_wr;
  logic              res_rd;
  logic [AW-1:0]     res_addr;
  logic [DIST_W-1:0] res_do;
  logic [DIST_W-1:0] res_di;

  modport master (
    input  start, metric, sti_di, res_di,
    output busy, done, sti_rd, sti_addr, res_wr, res_rd, res_addr, res_do
  );

  modport slave (
    output start, metric, sti_di, res_di,
    input  busy, done, sti_rd, sti_addr, res_wr, res_rd, res_addr, res_do
  );
endinterface

// File: rtl/dt_engine.sv
// Two-pass chessboard / city-block distance transform: LOAD expands the packed ROM image, FWD and BWD raster passes.
// Define DT_BORDER_CLEAR_EN to force every border pixel to background during LOAD.
module dt_engine #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int STI_W  = 16,
  parameter int DIST_W = 8
) (
  input logic        clk,
  input logic        reset,
  dt_engine_if.master bus
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = $clog2(IMG_W);
  localparam int SW   = $clog2(STI_W);

  localparam logic [AW-1:0]   FIRST_PIX = AW'(IMG_W + 1);
  localparam logic [AW-1:0]   LAST_PIX  = AW'((IMG_H - 2) * IMG_W + IMG_W - 2);
  localparam logic [AW-1:0]   END_LOAD  = AW'(NPIX - 1);
  localparam logic [DIST_W:0] DMAX      = (DIST_W + 1)'((1 << DIST_W) - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FWD, BWD, FIN} state_t;

  state_t            state_reg;
  logic              metric_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              sti_rd_reg;
  logic              res_wr_reg;
  logic              res_rd_reg;
  logic [AW-1:0]     res_addr_reg;
  logic [DIST_W-1:0] res_do_reg;
  logic [AW-1:0]     cen_reg;
  logic [2:0]        step_reg;
  logic [DIST_W-1:0] min_reg;
  logic [DIST_W-1:0] cen_val_reg;

  // Offset of the k-th neighbour (k = 1..4) relative to the centre pixel.
  function automatic logic [AW-1:0] nbr_off(input logic bwd, input logic city, input logic [2:0] k);
    int off;
    off = 0;
    if (city) begin
      if (k == 3'd1) off = bwd ? 1 : -IMG_W;
      else           off = bwd ? IMG_W : -1;
    end else begin
      case (k)
        3'd1:    off = bwd ? 1         : -IMG_W - 1;
        3'd2:    off = bwd ? IMG_W - 1 : -IMG_W;
        3'd3:    off = bwd ? IMG_W     : -IMG_W + 1;
        default: off = bwd ? IMG_W + 1 : -1;
      endcase
    end
    return AW'(off);
  endfunction

  // LOAD pixel: the ROM word holds STI_W pixels MSB first.
  logic [STI_W-1:0] sti_shift;
  logic             ld_bit;
  assign sti_shift = bus.sti_di << (res_addr_reg[CW-1:0] & CW'(STI_W - 1));
`ifdef DT_BORDER_CLEAR_EN
  logic [AW-CW-1:0] ld_row;
  logic [CW-1:0]    ld_col;
  logic             ld_border;
  assign ld_row    = res_addr_reg[AW-1:CW];
  assign ld_col    = res_addr_reg[CW-1:0];
  assign ld_border = (ld_row == '0) || (ld_row == (AW-CW)'(IMG_H - 1)) ||
                     (ld_col == '0) || (ld_col == CW'(IMG_W - 1));
  assign ld_bit    = sti_shift[STI_W-1] & ~ld_border;
`else
  assign ld_bit    = sti_shift[STI_W-1];
`endif

  logic              in_bwd;
  logic [2:0]        last_k;
  logic [DIST_W-1:0] nbr_min;
  logic [DIST_W:0]   inc;
  logic [DIST_W-1:0] inc_sat;
  logic [DIST_W-1:0] new_d;
  logic              pass_last;
  logic              col_edge;
  logic [AW-1:0]     cen_next;
  logic              adv;

  assign in_bwd  = (state_reg == BWD);
  assign last_k  = metric_reg ? 3'd2 : 3'd4;
  assign nbr_min = (bus.res_di < min_reg) ? bus.res_di : min_reg;
  assign inc     = {1'b0, nbr_min} + (DIST_W + 1)'(1);
  assign inc_sat = (inc > DMAX) ? DMAX[DIST_W-1:0] : inc[DIST_W-1:0];
  assign new_d   = (in_bwd && (cen_val_reg < inc_sat)) ? cen_val_reg : inc_sat;

  // Interior raster walk: a row change skips the two border columns (+/-3).
  assign pass_last = in_bwd ? (cen_reg == FIRST_PIX) : (cen_reg == LAST_PIX);
  assign col_edge  = in_bwd ? (cen_reg[CW-1:0] == CW'(1)) : (cen_reg[CW-1:0] == CW'(IMG_W - 2));
  assign cen_next  = in_bwd ? (cen_reg - (col_edge ? AW'(3) : AW'(1)))
                            : (cen_reg + (col_edge ? AW'(3) : AW'(1)));
  assign adv       = ((step_reg == 3'd0) && (bus.res_di == '0)) || (step_reg == last_k + 3'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      metric_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      sti_rd_reg   <= 1'b0;
      res_wr_reg   <= 1'b0;
      res_rd_reg   <= 1'b0;
      res_addr_reg <= '0;
      res_do_reg   <= '0;
      cen_reg      <= '0;
      step_reg     <= '0;
      min_reg      <= '0;
      cen_val_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg    <= LOAD;
            metric_reg   <= bus.metric;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
            sti_rd_reg   <= 1'b1;
            res_wr_reg   <= 1'b1;
            res_addr_reg <= '0;
          end
        end
        LOAD: begin
          if (res_addr_reg == END_LOAD) begin
            state_reg    <= FWD;
            sti_rd_reg   <= 1'b0;
            res_wr_reg   <= 1'b0;
            res_rd_reg   <= 1'b1;
            res_addr_reg <= FIRST_PIX;
            cen_reg      <= FIRST_PIX;
            step_reg     <= '0;
          end else begin
            res_addr_reg <= res_addr_reg + AW'(1);
          end
        end
        FWD, BWD: begin
          if (adv) begin
            res_wr_reg <= 1'b0;
            step_reg   <= '0;
            if (!pass_last) begin
              cen_reg      <= cen_next;
              res_addr_reg <= cen_next;
              res_rd_reg   <= 1'b1;
            end else if (!in_bwd) begin
              state_reg    <= BWD;
              cen_reg      <= LAST_PIX;
              res_addr_reg <= LAST_PIX;
              res_rd_reg   <= 1'b1;
            end else begin
              state_reg    <= FIN;
              res_rd_reg   <= 1'b0;
            end
          end else if (step_reg == 3'd0) begin
            cen_val_reg  <= bus.res_di;
            min_reg      <= '1;
            step_reg     <= 3'd1;
            res_addr_reg <= cen_reg + nbr_off(in_bwd, metric_reg, 3'd1);
          end else begin
            min_reg  <= nbr_min;
            step_reg <= step_reg + 3'd1;
            if (step_reg == last_k) begin
              res_rd_reg   <= 1'b0;
              res_wr_reg   <= 1'b1;
              res_addr_reg <= cen_reg;
              res_do_reg   <= new_d;
            end else begin
              res_addr_reg <= cen_reg + nbr_off(in_bwd, metric_reg, step_reg + 3'd1);
            end
          end
        end
        FIN: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.sti_rd   = sti_rd_reg;
  assign bus.sti_addr = sti_rd_reg ? res_addr_reg[AW-1:SW] : '0;
  assign bus.res_wr   = res_wr_reg;
  assign bus.res_rd   = res_rd_reg;
  assign bus.res_addr = res_addr_reg;
  // During LOAD the write data comes straight from the ROM word being addressed.
  assign bus.res_do   = sti_rd_reg ? DIST_W'(ld_bit) : res_do_reg;
endmodule
